// File: rtl/reset_seq_pkg.sv
// Shared types and widths for the reset sequencer: FSM state encoding,
// step/timeout counter width and failing-domain index width.
package reset_seq_pkg;

    localparam int CNT_W     = 8;
    localparam int ERR_DOM_W = 3;

    typedef enum logic [2:0] {
        HOLD,
        DELAY,
        ACK,
        DONE,
        ERR
    } seq_state_t;

endpackage

// File: rtl/reset_seq_ack_sync.sv
// Two-flop synchronizer bank that brings each domain's srst_n acknowledge
// into the mclk domain before the sequencer looks at it.
module reset_seq_ack_sync #(
    parameter int NUM_DOM = 4
) (
    input  logic               mclk,
    input  logic               reset,
    input  logic [NUM_DOM-1:0] dom_ack,
    output logic [NUM_DOM-1:0] ack_sync
);

    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge mclk) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= dom_ack[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign ack_sync[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/reset_seq_ctrl.sv
// Releases NUM_DOM reset domains one at a time in ascending order, waiting
// for each domain's acknowledge, with a bounded wait and a scan bypass.
import reset_seq_pkg::*;

module reset_seq_ctrl #(
    parameter int NUM_DOM = 4,
    parameter int TMO_CYC = 255
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic                 scan_mode,
    input  logic [7:0]           cfg_dly,
    input  logic                 sw_rst_req,
    input  logic [NUM_DOM-1:0]   dom_ack,
    output logic [NUM_DOM-1:0]   dom_rst_n,
    output logic                 seq_busy,
    output logic                 seq_done,
    output logic                 seq_err,
    output logic [ERR_DOM_W-1:0] err_dom
);

    localparam logic [ERR_DOM_W-1:0] LAST_IDX = ERR_DOM_W'(NUM_DOM - 1);
    localparam logic [CNT_W-1:0]     TMO_LIM  = CNT_W'(TMO_CYC);

    seq_state_t           state_reg;
    logic [CNT_W-1:0]     step_cnt_reg;
    logic [CNT_W-1:0]     tmo_cnt_reg;
    logic [ERR_DOM_W-1:0] idx_reg;
    logic [NUM_DOM-1:0]   rst_n_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic [ERR_DOM_W-1:0] err_dom_reg;

    logic [NUM_DOM-1:0]   ack_sync;
    logic [NUM_DOM-1:0]   idx_dec;
    logic                 ack_cur;

    reset_seq_ack_sync #(
        .NUM_DOM (NUM_DOM)
    ) u_ack_sync (
        .mclk     (mclk),
        .reset    (reset),
        .dom_ack  (dom_ack),
        .ack_sync (ack_sync)
    );

    // One-hot of the current domain; only its acknowledge is ever looked at.
    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dec
            assign idx_dec[gi]   = (idx_reg == ERR_DOM_W'(gi));
            assign dom_rst_n[gi] = scan_mode ? ~reset : rst_n_reg[gi];
        end
    endgenerate

    assign ack_cur = |(ack_sync & idx_dec);

    always_ff @(posedge mclk) begin
        if (reset || sw_rst_req) begin
            state_reg    <= HOLD;
            step_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            idx_reg      <= '0;
            rst_n_reg    <= '0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            if (reset) begin
                err_dom_reg <= '0;
            end
        end else begin
            case (state_reg)
                HOLD: begin
                    if (step_cnt_reg == cfg_dly) begin
                        state_reg    <= DELAY;
                        step_cnt_reg <= '0;
                        idx_reg      <= '0;
                    end else begin
                        step_cnt_reg <= step_cnt_reg + CNT_W'(1);
                    end
                end
                DELAY: begin
                    if (step_cnt_reg == cfg_dly) begin
                        rst_n_reg    <= rst_n_reg | idx_dec;
                        state_reg    <= ACK;
                        step_cnt_reg <= '0;
                        tmo_cnt_reg  <= '0;
                    end else begin
                        step_cnt_reg <= step_cnt_reg + CNT_W'(1);
                    end
                end
                ACK: begin
                    if (ack_cur) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg      <= idx_reg + ERR_DOM_W'(1);
                            state_reg    <= DELAY;
                            step_cnt_reg <= '0;
                        end
                    end else if (tmo_cnt_reg == TMO_LIM) begin
                        state_reg   <= ERR;
                        err_dom_reg <= idx_reg;
                        rst_n_reg   <= '0;
                        busy_reg    <= 1'b0;
                        err_reg     <= 1'b1;
                    end else begin
                        // Stops at the limit, so it can never wrap.
                        tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                    end
                end
                DONE, ERR: begin
                end
                default: begin
                    state_reg <= HOLD;
                end
            endcase
        end
    end

    assign seq_busy = busy_reg;
    assign seq_done = done_reg;
    assign seq_err  = err_reg;
    assign err_dom  = err_dom_reg;

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 4: number of sequenced reset domains (2..8).
REQ-002 Parameter TMO_CYC, default 255: maximum mclk cycles to wait for a domain acknowledge.
REQ-003 Port mclk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port scan_mode, input, 1: test-mode bypass.
REQ-006 Port cfg_dly, input, 8: inter-step delay; each step lasts cfg_dly+1 cycles.
REQ-007 Port sw_rst_req, input, 1: single-cycle soft-reset request, synchronous to mclk.
REQ-008 Port dom_ack, input, NUM_DOM: per-domain synchronized reset state (srst_n of each domain's synchronizer), asynchronous to mclk.
REQ-009 Port dom_rst_n, output, NUM_DOM: per-domain active-low reset; drives each synchronizer's arst_n.
REQ-010 Port seq_busy, output, 1: high while the sequence is in progress.
REQ-011 Port seq_done, output, 1: high when all domains are released and acknowledged.
REQ-012 Port seq_err, output, 1: high on acknowledge timeout.
REQ-013 Port err_dom, output, 3: index of the domain that timed out.

Function
REQ-014 dom_ack SHALL pass through a 2-flop synchronizer before use, so ack latency is 2 cycles.
REQ-015 The FSM SHALL have states HOLD, DELAY, ACK, DONE and ERR, plus a step counter (8 bits), a timeout counter (8 bits) and a domain index idx.
REQ-016 HOLD: all dom_rst_n SHALL be 0; after cfg_dly+1 cycles, go to DELAY with idx=0.
REQ-017 DELAY: after cfg_dly+1 cycles, set dom_rst_n[idx]=1 (registered, visible the next cycle) and go to ACK with the timeout counter cleared.
REQ-018 ACK: when synchronized dom_ack[idx]=1:
  - if idx=NUM_DOM-1, go to DONE;
  - otherwise increment idx and go to DELAY.
REQ-019 ACK timeout: if the timeout counter reaches TMO_CYC without an ack, go to ERR, latch err_dom=idx, and force all dom_rst_n to 0.
REQ-020 Release order SHALL be ascending index; already-released domains SHALL stay released until HOLD or ERR.
REQ-021 DONE: seq_done=1 and seq_busy=0; dom_rst_n stays all-ones.
REQ-022 ERR: seq_err=1, seq_busy=0 and all dom_rst_n=0; only sw_rst_req exits ERR.
REQ-023 sw_rst_req in any state SHALL take priority, and on the next edge:
  - go to HOLD and assert all dom_rst_n;
  - clear seq_err and seq_done;
  - reload counters.
REQ-024 seq_busy SHALL be 1 in HOLD, DELAY and ACK.
REQ-025 dom_ack bits other than idx SHALL be ignored in every state.
REQ-026 When scan_mode=1, dom_rst_n SHALL equal {NUM_DOM{~reset}} combinationally; the FSM continues to run unaffected.
REQ-027 The timeout counter SHALL saturate and SHALL NOT wrap.

Reset
REQ-028 While reset=1, on each edge the FSM SHALL enter HOLD with:
  - idx=0 and counters=0;
  - dom_rst_n=0, seq_busy=1, seq_done=0, seq_err=0, err_dom=0.
REQ-029 Deasserting reset SHALL start the sequence; the first domain releases no earlier than 2*(cfg_dly+1) cycles later.
REQ-030 Asserting reset mid-sequence SHALL re-assert all domain resets on the next edge.

Structure
REQ-031 Package reset_seq_pkg SHALL hold:
  - the state enum (HOLD, DELAY, ACK, DONE, ERR);
  - the counter width constant (8);
  - the err_dom width constant (3).
REQ-032 One sub-module, reset_seq_ack_sync, SHALL implement the NUM_DOM-wide 2-flop synchronizer; the FSM and counters live in reset_seq_ctrl.

Verification
REQ-033 Nominal: cfg_dly=3; each dom_ack follows its dom_rst_n after 1 cycle. Required: HOLD lasts 4 cycles; each release is spaced by 4 + ack latency; seq_done=1 after domain 3 acks.
REQ-034 Timeout: dom_ack[2] held at 0, TMO_CYC=255. Required: seq_err=1 and err_dom=2 at 256 cycles after domain 2 releases; all dom_rst_n=0.
REQ-035 Soft reset from DONE: pulse sw_rst_req. Required: dom_rst_n=0000 next cycle, seq_done=0, seq_busy=1, then full re-sequence.
REQ-036 Mid-sequence: sw_rst_req while in ACK for domain 1. Required: all domains asserted next cycle and restart from domain 0; separately, reset=1 in DELAY gives the same result.
REQ-037 Boundary: cfg_dly=0 gives 1-cycle steps; cfg_dly=255 gives 256-cycle steps; a glitch on dom_ack[3] while waiting on domain 1 is ignored.
REQ-038 Scan: scan_mode=1 with reset toggling makes dom_rst_n follow ~reset combinationally, independent of FSM state.
